// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by PC,
// a registered mispredict/redirect pulse, and saturating resolve/miss statistics.
module branch_predictor #(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    input  logic        if_valid,
    output logic        pred_taken,
    input  logic        ex_update,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic        ex_pred,
    output logic        mispredict,
    input  logic        stat_clr,
    output logic [15:0] branch_cnt,
    output logic [15:0] miss_cnt
);

    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    function automatic ctr_t ctr_step(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = ctr_t'(cur + 2'd1);
        end else begin
            if (cur != SNT) nxt = ctr_t'(cur - 2'd1);
        end
        return nxt;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    ctr_t             tbl_q [ENTRIES];
    ctr_t             upd_val_d;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             miss_d;
    logic             mispredict_q;
    logic [15:0]      branch_cnt_q, branch_cnt_d;
    logic [15:0]      miss_cnt_q, miss_cnt_d;

    // Word-aligned PCs: drop the two byte-offset bits; upper bits alias freely.
    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], ex_pc[31:IDX_W+2], ex_pc[1:0]};

    // Lookup reads the registered table, so a same-cycle update is not bypassed.
    assign pred_taken = if_valid & tbl_q[if_idx][1];
    assign upd_val_d  = ctr_step(tbl_q[ex_idx], ex_taken);
    assign miss_d     = ex_update & (ex_taken ^ ex_pred);

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (stat_clr) begin
            branch_cnt_d = 16'd0;
            miss_cnt_d   = 16'd0;
        end else if (ex_update) begin
            branch_cnt_d = sat_inc16(branch_cnt_q);
            if (miss_d) miss_cnt_d = sat_inc16(miss_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= WNT;
        end else if (ex_update) begin
            tbl_q[ex_idx] <= upd_val_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_q <= 1'b0;
            branch_cnt_q <= 16'd0;
            miss_cnt_q   <= 16'd0;
        end else begin
            mispredict_q <= miss_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign mispredict = mispredict_q;
    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomised and directed bench for branch_predictor against an integer-level
// model of the counter table and statistics.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = 32'd0;
    logic        if_valid = 1'b0;
    logic        pred_taken;
    logic        ex_update = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic        ex_taken = 1'b0;
    logic        ex_pred = 1'b0;
    logic        mispredict;
    logic        stat_clr = 1'b0;
    logic [15:0] branch_cnt;
    logic [15:0] miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    int tbl_m [16];
    int exp_b;
    int exp_m;
    bit exp_mis;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_valid(if_valid),
        .pred_taken(pred_taken), .ex_update(ex_update), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_pred(ex_pred), .mispredict(mispredict),
        .stat_clr(stat_clr), .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
    );

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 32'd16);
    endfunction

    function automatic bit model_pred();
        return if_valid && (tbl_m[idx_of(if_pc)] >= 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) tbl_m[i] = 1;
        exp_b = 0;
        exp_m = 0;
        exp_mis = 1'b0;
    endtask

    task automatic model_clock();
        int k;
        exp_mis = ex_update && (ex_taken != ex_pred);
        if (ex_update) begin
            k = idx_of(ex_pc);
            if (ex_taken) tbl_m[k] = (tbl_m[k] < 3) ? tbl_m[k] + 1 : 3;
            else          tbl_m[k] = (tbl_m[k] > 0) ? tbl_m[k] - 1 : 0;
            if (exp_b < 65535) exp_b = exp_b + 1;
            if (exp_mis && exp_m < 65535) exp_m = exp_m + 1;
        end
        if (stat_clr) begin
            exp_b = 0;
            exp_m = 0;
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_update = 1'b0;
        ex_taken  = 1'b0;
        ex_pred   = 1'b0;
        ex_pc     = 32'd0;
        stat_clr  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        if_pc = 32'h40;
        if_valid = 1'b1;
        #1;
        n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred got %b want 0", pred_taken); end
        n_tests++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mis got %b want 0", mispredict); end
        n_tests++; if (branch_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_bcnt got %h want 0", branch_cnt); end
        n_tests++; if (miss_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_mcnt got %h want 0", miss_cnt); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'(i * 4);
            #1;
            n_tests++;
            if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL post_reset_pred idx %0d got %b want 0", i, pred_taken); end
        end
    endtask

    task automatic test_train();
        do_reset();
        if_pc = 32'h40; if_valid = 1'b1;
        ex_update = 1'b1; ex_pc = 32'h40; ex_taken = 1'b1; ex_pred = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (pred_taken !== 1'b1 || pred_taken !== model_pred()) begin
                n_fail++; $display("FAIL train_pred step %0d got %b want 1", k, pred_taken);
            end
        end
        n_tests++;
        if (tbl_m[0] != 3) begin n_fail++; $display("FAIL train_model_state got %0d want 3", tbl_m[0]); end
        ex_update = 1'b0; ex_taken = 1'b0;
        tick();
        ex_update = 1'b1;
        tick();
        n_tests++;
        if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL train_st_hold got %b want 1", pred_taken); end
        tick();
        n_tests++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL train_decay got %b want 0", pred_taken); end
        idle_inputs();
    endtask

    task automatic test_alias();
        do_reset();
        if_pc = 32'h40; if_valid = 1'b1;
        ex_update = 1'b1; ex_pc = 32'h44; ex_taken = 1'b1; ex_pred = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL alias_0x44 got %b want 0", pred_taken); end
        if_pc = 32'h44;
        #1;
        n_tests++;
        if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alias_0x44_self got %b want 1", pred_taken); end
        if_pc = 32'h40;
        ex_pc = 32'h80;
        tick();
        n_tests++;
        if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alias_0x80 got %b want 1", pred_taken); end
        idle_inputs();
    endtask

    task automatic test_same_cycle();
        do_reset();
        if_pc = 32'h40; if_valid = 1'b1;
        ex_update = 1'b1; ex_pc = 32'h40; ex_taken = 1'b1; ex_pred = 1'b0;
        #1;
        n_tests++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL same_cycle_pre got %b want 0", pred_taken); end
        tick();
        ex_update = 1'b0;
        #1;
        n_tests++;
        if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL same_cycle_post got %b want 1", pred_taken); end
        if_valid = 1'b0;
        #1;
        n_tests++;
        if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL pred_gated got %b want 0", pred_taken); end
        idle_inputs();
    endtask

    task automatic test_mispredict();
        do_reset();
        ex_update = 1'b1; ex_pc = 32'h100; ex_taken = 1'b1; ex_pred = 1'b0;
        tick();
        idle_inputs();
        ex_taken = 1'b1; ex_pred = 1'b0;
        n_tests++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL mis_pulse got %b want 1", mispredict); end
        n_tests++; if (branch_cnt !== 16'd1) begin n_fail++; $display("FAIL mis_bcnt got %h want 1", branch_cnt); end
        n_tests++; if (miss_cnt !== 16'd1) begin n_fail++; $display("FAIL mis_mcnt got %h want 1", miss_cnt); end
        tick();
        n_tests++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL mis_one_cycle got %b want 0", mispredict); end
        n_tests++; if (branch_cnt !== 16'd1 || miss_cnt !== 16'd1) begin
            n_fail++; $display("FAIL mis_ignored_idle got %h/%h want 1/1", branch_cnt, miss_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_stat_clr();
        do_reset();
        ex_update = 1'b1; ex_pc = 32'h8; ex_taken = 1'b0; ex_pred = 1'b1;
        repeat (3) tick();
        stat_clr = 1'b1; ex_taken = 1'b1; ex_pred = 1'b0;
        tick();
        n_tests++; if (branch_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
            n_fail++; $display("FAIL clr_counts got %h/%h want 0/0", branch_cnt, miss_cnt);
        end
        n_tests++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL clr_mis got %b want 1", mispredict); end
        if_pc = 32'h8; if_valid = 1'b1;
        #1;
        n_tests++; if (pred_taken !== model_pred()) begin
            n_fail++; $display("FAIL clr_table got %b want %b", pred_taken, model_pred());
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int errs;
        do_reset();
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            if_pc     = $urandom;
            if_valid  = 1'($urandom_range(0, 3) != 0);
            ex_update = 1'($urandom_range(0, 3) != 0);
            ex_pc     = $urandom;
            ex_taken  = 1'($urandom);
            ex_pred   = 1'($urandom);
            stat_clr  = ($urandom_range(0, 29) == 0);
            #1;
            n_tests++;
            if (pred_taken !== model_pred()) begin
                n_fail++; $display("FAIL rnd_pred iter %0d got %b want %b", i, pred_taken, model_pred());
            end
            tick();
            n_tests++;
            if (mispredict !== exp_mis || branch_cnt !== 16'(exp_b) || miss_cnt !== 16'(exp_m)) begin
                n_fail++;
                $display("FAIL rnd_regs iter %0d got mis=%b b=%0d m=%0d want mis=%b b=%0d m=%0d",
                         i, mispredict, branch_cnt, miss_cnt, exp_mis, exp_b, exp_m);
            end
        end
        idle_inputs();
    endtask

    task automatic test_saturate();
        do_reset();
        ex_update = 1'b1; ex_pc = 32'h20; ex_taken = 1'b1; ex_pred = 1'b0;
        repeat (65535) tick();
        n_tests++;
        if (branch_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got %h want ffff", branch_cnt); end
        tick();
        n_tests++;
        if (branch_cnt !== 16'hFFFF || branch_cnt !== 16'(exp_b)) begin
            n_fail++; $display("FAIL sat_bcnt got %h want ffff", branch_cnt);
        end
        n_tests++;
        if (miss_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_mcnt got %h want ffff", miss_cnt); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        ex_update = 1'b1; ex_pc = 32'h40; ex_taken = 1'b1; ex_pred = 1'b0;
        repeat (2) tick();
        if_pc = 32'h40; if_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL arst_pred got %b want 0", pred_taken); end
        n_tests++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL arst_mis got %b want 0", mispredict); end
        n_tests++; if (branch_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
            n_fail++; $display("FAIL arst_counts got %h/%h want 0/0", branch_cnt, miss_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        ex_update = 1'b0;
        #1;
        n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL arst_discard got %b want 0", pred_taken); end
        ex_update = 1'b1;
        tick();
        n_tests++; if (branch_cnt !== 16'd1 || mispredict !== 1'b1) begin
            n_fail++; $display("FAIL arst_first_edge got b=%h mis=%b want 1/1", branch_cnt, mispredict);
        end
        n_tests++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL arst_relearn got %b want 1", pred_taken); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_train();
        test_alias();
        test_same_cycle();
        test_mispredict();
        test_stat_clr();
        test_random();
        test_async_reset();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning log2 of branch-history-table entries (16).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port if_pc  input  32  PC of instruction in IF.
REQ-005 SHALL have port if_valid  input  1  IF PC is a conditional branch being fetched.
REQ-006 SHALL have port pred_taken  output  1  select for the IF-stage 2:1 next-PC mux (1 = branch target, 0 = PC+4).
REQ-007 SHALL have port ex_update  input  1  EX resolves a conditional branch this cycle.
REQ-008 SHALL have port ex_pc  input  32  PC of the resolved branch.
REQ-009 SHALL have port ex_taken  input  1  actual branch outcome.
REQ-010 SHALL have port ex_pred  input  1  prediction carried down the pipe with that branch.
REQ-011 SHALL have port mispredict  output  1  registered flush/redirect request to the next-PC mux.
REQ-012 SHALL have port stat_clr  input  1  synchronous clear of statistics counters.
REQ-013 SHALL have port branch_cnt  output  16  resolved-branch count.
REQ-014 SHALL have port miss_cnt  output  16  mispredicted-branch count.

Function
REQ-015 SHALL hold 2^IDX_W two-bit saturating counters; index = pc[IDX_W+1:2] for both lookup and update.
REQ-016 SHALL encode counter states SNT=00, WNT=01, WT=10, ST=11.
REQ-017 SHALL drive pred_taken = if_valid AND counter[idx(if_pc)][1], combinationally, zero-cycle latency.
REQ-018 SHALL, on ex_update, step counter[idx(ex_pc)] up by one if ex_taken=1 (saturate at ST), down by one if ex_taken=0 (saturate at SNT).
REQ-019 SHALL leave all counters unchanged in any cycle with ex_update=0.
REQ-020 SHALL, when lookup and update hit the same index in one cycle, return the pre-update value to pred_taken (no bypass); the new value is visible the next cycle.
REQ-021 SHALL register mispredict = ex_update AND (ex_taken XOR ex_pred), asserted for exactly the one cycle following the resolving cycle.
REQ-022 SHALL increment branch_cnt on every ex_update and miss_cnt on every mispredicting ex_update, each saturating at 16'hFFFF (no wrap).
REQ-023 SHALL give stat_clr priority over increment: the cycle after stat_clr=1 both counters read 0 regardless of ex_update.
REQ-024 SHALL not let stat_clr affect the counter table or mispredict.
REQ-025 SHALL ignore ex_taken, ex_pred and ex_pc when ex_update=0.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force every table entry to WNT (01), mispredict to 0, branch_cnt and miss_cnt to 0.
REQ-027 SHALL, on rst_n assertion mid-update, discard that update; first state change after release occurs on the first rising edge with rst_n=1.
REQ-028 SHALL drive pred_taken=0 for every PC immediately after reset (all entries WNT).

Verification
REQ-029 SHALL cover: reset, then if_pc=0x40, if_valid=1 -> pred_taken=0.
REQ-030 SHALL cover: two ex_update with ex_pc=0x40, ex_taken=1 -> entry 0 goes WNT->WT->ST; pred_taken for 0x40 =1 from the cycle after the first update; a third taken update keeps ST.
REQ-031 SHALL cover: aliasing, ex_pc=0x80 (idx 0 for IDX_W=4) taken updates change prediction for if_pc=0x40; ex_pc=0x44 does not.
REQ-032 SHALL cover: same-cycle lookup/update on idx 0 from WNT with ex_taken=1 -> pred_taken=0 that cycle, 1 the next.
REQ-033 SHALL cover: ex_update=1, ex_taken=1, ex_pred=0 -> mispredict=1 for exactly one cycle; branch_cnt=1, miss_cnt=1; 0x10000 updates -> branch_cnt holds 0xFFFF.
REQ-034 SHALL cover: stat_clr=1 together with mispredicting ex_update -> counters read 0, mispredict=1 next cycle; rst_n pulsed low mid-run -> all outputs 0 asynchronously.
